d_trig_wr_arbiter: RTL and testbench

//   Round-robin write arbiter that shares one enabled D register (i_d/i_enable/o_q style) among
//   N_REQ requesters. Picks one pending requester, drives the shared register's data and

---
 rtl/d_trig_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_d_trig_wr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/d_trig_wr_arbiter.sv
// Round-robin write arbiter for one shared enabled D register.
// One-cycle write per grant, then a programmable idle gap.
module d_trig_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_clr,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  output logic [N_REQ-1:0]          o_gnt,
  output logic [$clog2(N_REQ)-1:0]  o_idx,
  output logic                      o_enable,
  output logic [DATA_W-1:0]         o_d,
  output logic                      o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IW:0] NR = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n, nxt_ptr, arb_ptr;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IW-1:0]     idx_n, win;
  logic              en_n, busy_n, arb_ok, found;
  logic [DATA_W-1:0] d_n, wdata;
  logic [IW:0]       pos;

  assign nxt_ptr = (o_idx == IW'(N_REQ - 1)) ? '0 : o_idx + 1'b1;
  // Back-to-back mode arbitrates on the WRITE exit edge with the advanced pointer
  assign arb_ptr = (state == WRITE) ? nxt_ptr : ptr;

  always_comb begin
    win   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = {1'b0, arb_ptr} + (IW+1)'(i);
      if (pos >= NR) pos = pos - NR;
      if (!found && i_req[pos[IW-1:0]]) begin
        found = 1'b1;
        win   = pos[IW-1:0];
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IW'(k)) wdata = i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = '0;
    idx_n   = o_idx;
    en_n    = 1'b0;
    d_n     = o_d;
    busy_n  = 1'b0;
    arb_ok  = 1'b0;
    unique case (state)
      IDLE: arb_ok = 1'b1;
      WRITE: begin
        ptr_n = nxt_ptr;
        if (GAP_CYCLES == 0) begin
          arb_ok = 1'b1;
        end else begin
          state_n = GAP;
          cnt_n   = CW'(GAP_CYCLES);
          busy_n  = 1'b1;
        end
      end
      GAP: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) state_n = IDLE;
        else busy_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (arb_ok) begin
      if (found) begin
        state_n = WRITE;
        en_n    = 1'b1;
        gnt_n   = N_REQ'(1) << win;
        idx_n   = win;
        d_n     = wdata;
        busy_n  = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      o_gnt    <= '0;
      o_idx    <= '0;
      o_enable <= 1'b0;
      o_d      <= '0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      o_gnt    <= gnt_n;
      o_idx    <= idx_n;
      o_enable <= en_n;
      o_d      <= d_n;
      o_busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_d_trig_wr_arbiter.sv
// Directed bench for d_trig_wr_arbiter: one gapped and one
// back-to-back instance, plus a model of the shared D register.
module tb_d_trig_wr_arbiter;

  logic        clk = 1'b1;
  logic        clr;
  logic [3:0]  req, req0;
  logic [31:0] data, data0;
  logic [3:0]  gnt, gnt0;
  logic [1:0]  idx, idx0;
  logic        en, en0, busy, busy0;
  logic [7:0]  d, d0, q;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_trig_wr_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYCLES(1)) dut (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_data(data),
    .o_gnt(gnt), .o_idx(idx), .o_enable(en), .o_d(d), .o_busy(busy)
  );

  d_trig_wr_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYCLES(0)) dut0 (
    .i_clk(clk), .i_clr(clr), .i_req(req0), .i_data(data0),
    .o_gnt(gnt0), .o_idx(idx0), .o_enable(en0), .o_d(d0), .o_busy(busy0)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) q <= '0;
    else if (en) q <= d;
  end

  always @(negedge clk) begin
    if (!clr) begin
      vectors++;
      if (en !== |gnt || $countones(gnt) > 1) begin
        $display("FAIL onehot: gnt=%b en=%b", gnt, en);
        miscompares++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1; req = '0; req0 = '0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; req = '0; req0 = '0; data = '0; data0 = '0;
    #1;
    vectors++;
    if ({gnt, idx, en, d, busy} !== 16'h0) begin
      $display("FAIL reset_async: got %h want 0", {gnt, idx, en, d, busy});
      miscompares++;
    end
    #14 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({gnt, idx, en, d, busy} !== 16'h0) begin
        $display("FAIL reset_idle%0d: got %h want 0", i, {gnt, idx, en, d, busy});
        miscompares++;
      end
    end
  endtask

  task automatic test_single();
    data = 32'h00A5_0000;
    req  = 4'b0100;
    @(negedge clk);
    vectors++;
    if ({gnt, idx, en, d, busy} !== {4'b0100, 2'd2, 1'b1, 8'hA5, 1'b1}) begin
      $display("FAIL single_write: got %h want %h", {gnt, idx, en, d, busy},
               {4'b0100, 2'd2, 1'b1, 8'hA5, 1'b1});
      miscompares++;
    end
    req = 4'b0001;
    @(negedge clk);
    vectors++;
    if ({gnt, en, busy, d, q} !== {4'b0, 1'b0, 1'b1, 8'hA5, 8'hA5}) begin
      $display("FAIL single_gap: got %h want %h", {gnt, en, busy, d, q},
               {4'b0, 1'b0, 1'b1, 8'hA5, 8'hA5});
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({en, busy} !== 2'b00) begin
      $display("FAIL single_idle: got %b want 00", {en, busy});
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if ({gnt, idx, en} !== {4'b0001, 2'd0, 1'b1}) begin
      $display("FAIL wrap_from3: got %h want %h", {gnt, idx, en}, {4'b0001, 2'd0, 1'b1});
      miscompares++;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_all_held();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d;
    do_reset();
    data = 32'h4433_2211;
    req  = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_d = 8'h11 * 8'(order[n] + 1);
      @(negedge clk);
      vectors++;
      if ({gnt, idx, en, d} !== {4'b1 << order[n], 2'(order[n]), 1'b1, exp_d}) begin
        $display("FAIL rr_write%0d: got %h want %h", n, {gnt, idx, en, d},
                 {4'b1 << order[n], 2'(order[n]), 1'b1, exp_d});
        miscompares++;
      end
      @(negedge clk);
      vectors++;
      if ({en, busy, q} !== {1'b0, 1'b1, exp_d}) begin
        $display("FAIL rr_gap%0d: got %h want %h", n, {en, busy, q}, {1'b0, 1'b1, exp_d});
        miscompares++;
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g [3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [7:0] exp_d [3] = '{8'hB2, 8'hD4, 8'hB2};
    do_reset();
    data0 = 32'hD4C3_B2A1;
    req0  = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      vectors++;
      if ({gnt0, en0, busy0, d0} !== {exp_g[n], 1'b1, 1'b1, exp_d[n]}) begin
        $display("FAIL b2b_write%0d: got %h want %h", n, {gnt0, en0, busy0, d0},
                 {exp_g[n], 1'b1, 1'b1, exp_d[n]});
        miscompares++;
      end
    end
    req0 = '0;
    @(negedge clk);
    vectors++;
    if ({gnt0, en0, busy0} !== 6'b0) begin
      $display("FAIL b2b_idle: got %b want 0", {gnt0, en0, busy0});
      miscompares++;
    end
  endtask

  task automatic test_data_change();
    do_reset();
    data = 32'h0000_1100;
    req  = 4'b0010;
    @(posedge clk);
    #1 data = 32'h0000_2200;
    @(negedge clk);
    vectors++;
    if ({gnt, en, d} !== {4'b0010, 1'b1, 8'h11}) begin
      $display("FAIL data_hold_write: got %h want %h", {gnt, en, d}, {4'b0010, 1'b1, 8'h11});
      miscompares++;
    end
    req = '0;
    @(negedge clk);
    vectors++;
    if ({d, q} !== 16'h1111) begin
      $display("FAIL data_hold_gap: got %h want 1111", {d, q});
      miscompares++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    data = 32'h4433_2211;
    req  = 4'b1000;
    @(negedge clk);
    vectors++;
    if ({gnt, en} !== {4'b1000, 1'b1}) begin
      $display("FAIL rst_pre: got %b want 10001", {gnt, en});
      miscompares++;
    end
    #2 clr = 1'b1;
    #1;
    vectors++;
    if ({gnt, idx, en, busy} !== 8'h0) begin
      $display("FAIL rst_mid_write: got %h want 0", {gnt, idx, en, busy});
      miscompares++;
    end
    req = 4'b1001;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if ({gnt, idx, en, d} !== {4'b0001, 2'd0, 1'b1, 8'h11}) begin
      $display("FAIL rst_first_grant: got %h want %h", {gnt, idx, en, d},
               {4'b0001, 2'd0, 1'b1, 8'h11});
      miscompares++;
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_held();
    test_back_to_back();
    test_data_change();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
